// File: rtl/sap_ram.sv
// SAP-1 16x8 program/data RAM: manual button-programmed writes with debounce, bus writes/reads in run mode.
// Reads are combinational; writes land on a rising edge; reset clears every word asynchronously.
module sap_ram #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] addr,
  input  logic [7:0] prog_data,
  input  logic       prog,
  input  logic       n_write_btn,
  input  logic [7:0] bus_in,
  input  logic       n_ram_in,
  input  logic       n_ram_out,
  output logic [7:0] bus_out,
  output logic       bus_oe,
  output logic       wr_done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    WRITE    = 2'd2,
    RELEASE  = 2'd3
  } state_e;

  localparam logic [3:0] CNT_LAST = 4'(DEBOUNCE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sync1_q, sync2_q;
  logic       wr_done_q;
  logic [7:0] mem_q [16];
  logic       btn_s;
  logic       fsm_we;
  logic       run_we;

  // Synchronizer resets to the released (high) level so a held button reads as a fresh press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= n_write_btn;
      sync2_q <= sync1_q;
    end
  end

  assign btn_s = ~sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      wr_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_done_q <= (state_q == WRITE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (prog && btn_s) begin
          state_d = DEBOUNCE;
          cnt_d   = 4'd1;
        end
      end
      DEBOUNCE: begin
        if (!prog || !btn_s) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WRITE: begin
        state_d = prog ? RELEASE : IDLE;
        cnt_d   = 4'd0;
      end
      RELEASE: begin
        // The button must read released for DEBOUNCE_CYCLES samples in a row; any bounce restarts it.
        if (!prog) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (btn_s) begin
          cnt_d = 4'd0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // A WRITE already entered always completes, even if prog has just fallen.
  assign fsm_we = (state_q == WRITE);
  assign run_we = !prog && !n_ram_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else if (fsm_we) begin
      mem_q[addr] <= prog_data;
    end else if (run_we) begin
      mem_q[addr] <= bus_in;
    end
  end

  assign bus_oe  = rst_n && !prog && !n_ram_out;
  assign bus_out = bus_oe ? mem_q[addr] : 8'h00;
  assign wr_done = wr_done_q;

endmodule

// File: tb/tb_sap_ram.sv
// Bench for sap_ram: directed button/bus scenarios plus randomized run-mode traffic and random-length presses.
module tb_sap_ram;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] addr;
  logic [7:0] prog_data;
  logic       prog;
  logic       n_write_btn;
  logic [7:0] bus_in;
  logic       n_ram_in;
  logic       n_ram_out;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic       wr_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [16];

  sap_ram #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .prog_data  (prog_data),
    .prog       (prog),
    .n_write_btn(n_write_btn),
    .bus_in     (bus_in),
    .n_ram_in   (n_ram_in),
    .n_ram_out  (n_ram_out),
    .bus_out    (bus_out),
    .bus_oe     (bus_oe),
    .wr_done    (wr_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
  endtask

  // Run-mode read of one word, compared against the model.
  task automatic read_chk(input string tag, input logic [3:0] a);
    prog = 1'b0; n_ram_in = 1'b1; n_ram_out = 1'b0; addr = a;
    @(negedge clk);
    chk({tag, "_oe"}, 32'(bus_oe), 32'd1);
    chk(tag, 32'(bus_out), 32'(mdl[a]));
    step();
    n_ram_out = 1'b1;
  endtask

  // Button held low for the samples taken at edges 0..len-1; addr/data switch to their final values
  // after edge 2, so a write must use the final pair. A press of at least D samples writes once.
  task automatic press(input int len, input logic [3:0] a0, input logic [3:0] a1,
                       input logic [7:0] d, output int pulses, output int at);
    pulses = 0; at = -1;
    prog = 1'b1; n_ram_in = 1'b1; n_ram_out = 1'b1;
    addr = a0; prog_data = ~d; n_write_btn = 1'b0;
    for (int e = 0; e < 20; e++) begin
      step();
      if (wr_done) begin pulses++; at = e; end
      if (e == 2) begin addr = a1; prog_data = d; end
      if (e == len - 1) n_write_btn = 1'b1;
    end
    n_write_btn = 1'b1;
    for (int e = 0; e < 10; e++) begin
      step();
      if (wr_done) pulses++;
    end
    if (len >= D) mdl[a1] = d;
  endtask

  initial begin
    int pulses, at;
    logic [3:0] a0, a1;
    logic [7:0] d;
    int len;

    clear_model();
    rst_n = 1'b0; addr = 4'h0; prog_data = 8'h00; prog = 1'b0; n_write_btn = 1'b1;
    bus_in = 8'h00; n_ram_in = 1'b1; n_ram_out = 1'b0;
    #3;
    chk("rst_oe", 32'(bus_oe), 32'd0);
    chk("rst_out", 32'(bus_out), 32'd0);
    chk("rst_wr_done", 32'(wr_done), 32'd0);
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 4'($urandom_range(0, 15));
      @(negedge clk);
      chk("post_rst_oe", 32'(bus_oe), 32'd1);
      chk("post_rst_out", 32'(bus_out), 32'd0);
      step();
    end

    // Long press: write on edge 6, one pulse, readback.
    press(20, 4'h3, 4'h3, 8'hA5, pulses, at);
    chk("press_pulses", 32'(pulses), 32'd1);
    chk("press_edge", 32'(at), 32'd6);
    prog = 1'b1; n_ram_out = 1'b0;
    @(negedge clk);
    chk("prog_oe", 32'(bus_oe), 32'd0);
    chk("prog_out", 32'(bus_out), 32'd0);
    step();
    read_chk("read_a5", 4'h3);

    // Bounce of 3 samples: nothing written, FSM idle so the next press keeps the full latency.
    press(3, 4'h9, 4'h9, 8'h11, pulses, at);
    chk("bounce_pulses", 32'(pulses), 32'd0);
    read_chk("bounce_mem", 4'h9);
    press(20, 4'h9, 4'h9, 8'h22, pulses, at);
    chk("after_bounce_edge", 32'(at), 32'd6);
    read_chk("after_bounce_mem", 4'h9);

    // Simultaneous bus write and read of the same word.
    prog = 1'b0; addr = 4'hF; bus_in = 8'h3C; n_ram_in = 1'b0; n_ram_out = 1'b0;
    @(negedge clk);
    chk("rw_before", 32'(bus_out), 32'(mdl[4'hF]));
    step();
    mdl[4'hF] = 8'h3C;
    n_ram_in = 1'b1;
    @(negedge clk);
    chk("rw_after", 32'(bus_out), 32'h3C);
    step();

    // prog dropped during debounce cancels the press.
    prog = 1'b1; addr = 4'h5; prog_data = 8'hC3; n_write_btn = 1'b0; n_ram_out = 1'b1;
    pulses = 0;
    for (int e = 0; e < 15; e++) begin
      step();
      if (wr_done) pulses++;
      if (e == 3) prog = 1'b0;
    end
    chk("cancel_pulses", 32'(pulses), 32'd0);
    n_write_btn = 1'b1;
    read_chk("cancel_mem", 4'h5);
    for (int e = 0; e < 5; e++) step();
    press(20, 4'h5, 4'h5, 8'hC3, pulses, at);
    chk("repress_pulses", 32'(pulses), 32'd1);
    read_chk("repress_mem", 4'h5);

    // Randomized run-mode traffic against the array model.
    for (int i = 0; i < 300; i++) begin
      prog = 1'b0;
      addr = 4'($urandom_range(0, 15));
      bus_in = 8'($urandom);
      n_ram_in = ($urandom_range(0, 2) != 0);
      n_ram_out = ($urandom_range(0, 3) == 0);
      @(negedge clk);
      if ((i % 10) == 0 || !n_ram_in) begin
        chk("rnd_oe", 32'(bus_oe), 32'(!n_ram_out));
        chk("rnd_out", 32'(bus_out), n_ram_out ? 32'd0 : 32'(mdl[addr]));
      end
      step();
      if (!n_ram_in) mdl[addr] = bus_in;
    end
    n_ram_in = 1'b1;

    // Random-length presses with an address change mid-debounce.
    for (int k = 0; k < 12; k++) begin
      len = $urandom_range(1, 12);
      a0 = 4'($urandom_range(0, 15));
      a1 = 4'($urandom_range(0, 15));
      d = 8'($urandom);
      press(len, a0, a1, d, pulses, at);
      chk("rnd_press_pulses", 32'(pulses), (len >= D) ? 32'd1 : 32'd0);
      if (len >= D) chk("rnd_press_edge", 32'(at), 32'd6);
      read_chk("rnd_press_a1", a1);
      read_chk("rnd_press_a0", a0);
    end

    // Reset during RELEASE clears memory at once; a held button then counts as a new press.
    prog = 1'b1; addr = 4'h7; prog_data = 8'h5A; n_write_btn = 1'b0; n_ram_out = 1'b1;
    for (int e = 0; e < 7; e++) step();
    chk("pre_rst_wr_done", 32'(wr_done), 32'd1);
    mdl[7] = 8'h5A;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("mid_rst_wr_done", 32'(wr_done), 32'd0);
    chk("mid_rst_oe", 32'(bus_oe), 32'd0);
    chk("mid_rst_out", 32'(bus_out), 32'd0);
    step(); step();
    rst_n = 1'b1;
    prog_data = 8'h77;
    pulses = 0; at = -1;
    for (int e = 0; e < 20; e++) begin
      step();
      if (wr_done) begin pulses++; at = e; end
    end
    n_write_btn = 1'b1;
    for (int e = 0; e < 10; e++) step();
    mdl[7] = 8'h77;
    chk("held_rst_pulses", 32'(pulses), 32'd1);
    chk("held_rst_edge", 32'(at), 32'd6);
    read_chk("held_rst_mem", 4'h7);
    read_chk("cleared_mem", 4'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sap_ram.md
SAP_RAM -- requirements
Module: sap_ram

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized samples required to accept a button press or release (legal range 2..15).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port addr  input  4  memory address driven by the MAR.
REQ-005 SHALL have port prog_data  input  8  write data driven by the input register in program mode.
REQ-006 SHALL have port prog  input  1  1 = program mode, 0 = run mode.
REQ-007 SHALL have port n_write_btn  input  1  asynchronous active-low manual write push-button.
REQ-008 SHALL have port bus_in  input  8  system bus value.
REQ-009 SHALL have port n_ram_in  input  1  active-low run-mode write-from-bus control.
REQ-010 SHALL have port n_ram_out  input  1  active-low run-mode drive-to-bus control.
REQ-011 SHALL have port bus_out  output  8  memory word presented to the bus.
REQ-012 SHALL have port bus_oe  output  1  high when bus_out is valid for the bus.
REQ-013 SHALL have port wr_done  output  1  one-cycle pulse after each program-mode write.

Function
REQ-014 SHALL hold 16 x 8-bit words; read is combinational from addr.
REQ-015 SHALL pass n_write_btn through a 2-flop synchronizer; btn_s = inverted second-stage output (1 = pressed).
REQ-016 SHALL implement program FSM states IDLE, DEBOUNCE, WRITE, RELEASE with a 4-bit counter cnt.
REQ-017 IDLE: prog=1 and btn_s=1 -> DEBOUNCE with cnt=1; otherwise stay.
REQ-018 DEBOUNCE: prog=0 or btn_s=0 -> IDLE with no write; cnt==DEBOUNCE_CYCLES-1 -> WRITE; else cnt+1.
REQ-019 WRITE (exactly one cycle): mem[addr] <= prog_data on the leaving edge; -> RELEASE with cnt=0; wr_done=1 for the following cycle only.
REQ-020 RELEASE: prog=0 -> IDLE; btn_s=1 -> cnt=0; btn_s=0 -> cnt+1; when cnt reaches DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE. Exactly one write per press, never auto-repeat.
REQ-021 With n_write_btn held low from edge 0 (first edge sampling it low), memory SHALL update at edge DEBOUNCE_CYCLES+2 (edge 6 for the default).
REQ-022 Run mode (prog=0): n_ram_in=0 at a rising edge -> mem[addr] <= bus_in; program FSM stays in IDLE.
REQ-023 Program mode (prog=1): n_ram_in and n_ram_out SHALL be ignored; bus_oe=0.
REQ-024 Run mode: n_ram_out=0 -> bus_oe=1, bus_out=mem[addr]; otherwise bus_oe=0, bus_out=8'h00.
REQ-025 n_ram_in=0 and n_ram_out=0 together: write occurs; bus_out shows the old word until the edge, the new word after it.
REQ-026 prog falling while in DEBOUNCE/WRITE/RELEASE SHALL return the FSM to IDLE on the next edge; a WRITE already entered completes its write.
REQ-027 addr changes during DEBOUNCE SHALL NOT cancel the press; the write uses addr and prog_data sampled at the WRITE edge.

Reset
REQ-028 rst_n=0 SHALL immediately clear all 16 words to 8'h00, clear the synchronizer to released, set FSM=IDLE, cnt=0, wr_done=0, bus_oe=0, bus_out=8'h00.
REQ-029 A press held across reset release SHALL be treated as a new press (write after REQ-021 latency).

Verification
REQ-030 Reset, prog=0, n_ram_out=0, any addr -> bus_oe=1, bus_out=8'h00.
REQ-031 prog=1, addr=4'h3, prog_data=8'hA5, button low 20 cycles -> mem[3]=A5 at edge 6, exactly one wr_done pulse; then run mode, addr=3, n_ram_out=0 -> bus_out=A5.
REQ-032 Button low 3 cycles then high (bounce) -> no write, no wr_done; FSM back in IDLE.
REQ-033 prog=0, addr=4'hF, bus_in=8'h3C, n_ram_in=0 one cycle, n_ram_out=0 held -> bus_out 00 before edge, 3C after.
REQ-034 prog=1, button held, prog dropped during DEBOUNCE -> no write; prog=1 and release/press again -> exactly one write.
REQ-035 Write mem[7]=8'h5A, assert rst_n=0 mid-RELEASE -> mem[7]=00, wr_done=0, bus_oe=0 with no clock edge required.
